// File: rtl/ps_axi_fifo_bridge_pkg.sv
// Shared definitions for the PS AXI FIFO bridge: register offsets, response codes, FSM states.
package ps_axi_fifo_bridge_pkg;
  localparam logic [7:0] OFS_TX_DATA  = 8'h00;
  localparam logic [7:0] OFS_TX_FREE  = 8'h04;
  localparam logic [7:0] OFS_RX_DATA  = 8'h08;
  localparam logic [7:0] OFS_RX_OCC   = 8'h0C;
  localparam logic [7:0] OFS_SOFT_RST = 8'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_beat_t;
endpackage

// File: rtl/ps_axi_fifo_bridge_fifo.sv
// First-word-fall-through FIFO with occupancy count; push is refused when full at cycle start.
module bridge_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head is forced to zero while empty so nothing stale leaks onto the ports.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !clr) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ps_axi_fifo_bridge.sv
// AXI4 slave exposing a TX/RX stream FIFO pair as a small register map (fixed-address bursts).
// Optional PS_BRIDGE_SOFT_RESET_EN adds a soft_reset register at 0x10.
module ps_axi_fifo_bridge
  import ps_axi_fifo_bridge_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ID_W  = 12
) (
  input  logic            clock,
  input  logic            reset,
`ifdef PS_BRIDGE_SOFT_RESET_EN
  output logic            soft_reset,
`endif
  input  logic            s_aw_valid,
  output logic            s_aw_ready,
  input  logic [31:0]     s_aw_addr,
  input  logic [ID_W-1:0] s_aw_id,
  input  logic [7:0]      s_aw_len,
  input  logic            s_w_valid,
  output logic            s_w_ready,
  input  logic [31:0]     s_w_data,
  input  logic [3:0]      s_w_strb,
  input  logic            s_w_last,
  output logic            s_b_valid,
  input  logic            s_b_ready,
  output logic [ID_W-1:0] s_b_id,
  output logic [1:0]      s_b_resp,
  input  logic            s_ar_valid,
  output logic            s_ar_ready,
  input  logic [31:0]     s_ar_addr,
  input  logic [ID_W-1:0] s_ar_id,
  input  logic [7:0]      s_ar_len,
  output logic            s_r_valid,
  input  logic            s_r_ready,
  output logic [31:0]     s_r_data,
  output logic [ID_W-1:0] s_r_id,
  output logic [1:0]      s_r_resp,
  output logic            s_r_last,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic [31:0]     tx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  input  logic [31:0]     rx_data
);
  localparam int CW = $clog2(DEPTH) + 1;

  wr_state_t w_state, w_next;
  rd_state_t r_state, r_next;

  logic [7:0]      w_ofs, r_ofs;
  logic [ID_W-1:0] w_id, r_id;
  logic            w_err;
  logic [7:0]      r_cnt;
  logic            w_beat, r_beat, beat_err, soft_wr, fifo_clr;
  logic            tx_push, tx_full, tx_empty, rx_pop, rx_full, rx_empty;
  logic [31:0]     rx_head;
  logic [CW-1:0]   tx_count, rx_count, tx_free;
  rd_beat_t        beat;
  logic            unused_ok;

  assign unused_ok = ^{s_w_strb, s_aw_addr[31:8], s_ar_addr[31:8]};

  bridge_fifo #(.DEPTH(DEPTH), .W(32)) u_tx (
    .clock(clock), .reset(reset), .clr(fifo_clr),
    .push(tx_push), .push_data(s_w_data),
    .pop(tx_valid && tx_ready), .pop_data(tx_data),
    .full(tx_full), .empty(tx_empty), .count(tx_count));

  bridge_fifo #(.DEPTH(DEPTH), .W(32)) u_rx (
    .clock(clock), .reset(reset), .clr(fifo_clr),
    .push(rx_valid && rx_ready), .push_data(rx_data),
    .pop(rx_pop), .pop_data(rx_head),
    .full(rx_full), .empty(rx_empty), .count(rx_count));

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;
  assign tx_free  = CW'(DEPTH) - tx_count;

  // Write FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (s_aw_valid)             w_next = W_DATA;
      W_DATA:  if (s_w_valid && s_w_last)  w_next = W_RESP;
      W_RESP:  if (s_b_ready)              w_next = W_IDLE;
      default:                             w_next = W_IDLE;
    endcase
  end

  always_comb begin
    s_aw_ready = (w_state == W_IDLE);
    s_w_ready  = (w_state == W_DATA);
    s_b_valid  = (w_state == W_RESP);
    s_b_id     = w_id;
    s_b_resp   = w_err ? RESP_SLVERR : RESP_OKAY;
  end

  assign w_beat   = s_w_valid && s_w_ready;
  assign tx_push  = w_beat && (w_ofs == OFS_TX_DATA) && !tx_full;
  assign beat_err = w_beat && !(tx_push || soft_wr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_ofs <= '0;
      w_id  <= '0;
      w_err <= 1'b0;
    end else if (s_aw_valid && s_aw_ready) begin
      w_ofs <= s_aw_addr[7:0];
      w_id  <= s_aw_id;
      w_err <= 1'b0;
    end else if (beat_err) begin
      w_err <= 1'b1;
    end
  end

`ifdef PS_BRIDGE_SOFT_RESET_EN
  logic soft_q;
  assign soft_wr    = w_beat && (w_ofs == OFS_SOFT_RST);
  assign fifo_clr   = soft_wr && s_w_data[0];
  assign soft_reset = soft_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        soft_q <= 1'b1;
    else if (soft_wr) soft_q <= s_w_data[0];
  end
`else
  assign soft_wr  = 1'b0;
  assign fifo_clr = 1'b0;
`endif

  // Read FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (s_ar_valid)                  r_next = R_DATA;
      R_DATA:  if (s_r_ready && r_cnt == 8'd0)  r_next = R_IDLE;
      default:                                  r_next = R_IDLE;
    endcase
  end

  always_comb begin
    beat = '{data: 32'd0, resp: RESP_SLVERR};
    case (r_ofs)
      OFS_TX_FREE: beat = '{data: 32'(tx_free),  resp: RESP_OKAY};
      OFS_RX_OCC:  beat = '{data: 32'(rx_count), resp: RESP_OKAY};
      OFS_RX_DATA: if (!rx_empty) beat = '{data: rx_head, resp: RESP_OKAY};
`ifdef PS_BRIDGE_SOFT_RESET_EN
      OFS_SOFT_RST: beat = '{data: {31'd0, soft_q}, resp: RESP_OKAY};
`endif
      default: ;
    endcase
  end

  always_comb begin
    s_ar_ready = (r_state == R_IDLE);
    s_r_valid  = (r_state == R_DATA);
    s_r_last   = (r_state == R_DATA) && (r_cnt == 8'd0);
    s_r_id     = r_id;
    s_r_data   = s_r_valid ? beat.data : 32'd0;
    s_r_resp   = s_r_valid ? beat.resp : RESP_OKAY;
  end

  assign r_beat = s_r_valid && s_r_ready;
  assign rx_pop = r_beat && (r_ofs == OFS_RX_DATA) && !rx_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ofs <= '0;
      r_id  <= '0;
      r_cnt <= '0;
    end else if (s_ar_valid && s_ar_ready) begin
      r_ofs <= s_ar_addr[7:0];
      r_id  <= s_ar_id;
      r_cnt <= s_ar_len;
    end else if (r_beat && r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end
endmodule

// File: tb/tb_ps_axi_fifo_bridge.sv
// Scoreboard bench for ps_axi_fifo_bridge (default build, DEPTH=16).
module tb_ps_axi_fifo_bridge;
  localparam int DEPTH = 16;
  localparam int ID_W  = 12;
  typedef logic [ID_W+34:0] rbeat_t;   // {id, data, resp, last}
  typedef logic [ID_W+1:0]  bbeat_t;   // {id, resp}

  logic clock = 1'b0, reset = 1'b1;
  logic s_aw_valid = 0, s_aw_ready; logic [31:0] s_aw_addr = 0; logic [ID_W-1:0] s_aw_id = 0; logic [7:0] s_aw_len = 0;
  logic s_w_valid = 0, s_w_ready; logic [31:0] s_w_data = 0; logic [3:0] s_w_strb = 4'hF; logic s_w_last = 0;
  logic s_b_valid, s_b_ready = 0; logic [ID_W-1:0] s_b_id; logic [1:0] s_b_resp;
  logic s_ar_valid = 0, s_ar_ready; logic [31:0] s_ar_addr = 0; logic [ID_W-1:0] s_ar_id = 0; logic [7:0] s_ar_len = 0;
  logic s_r_valid, s_r_ready = 0; logic [31:0] s_r_data; logic [ID_W-1:0] s_r_id; logic [1:0] s_r_resp; logic s_r_last;
  logic tx_valid, tx_ready = 1; logic [31:0] tx_data;
  logic rx_valid = 0, rx_ready; logic [31:0] rx_data = 0;

  int total = 0, bad = 0, cyc = 0, w_last_cyc = 0;
  bbeat_t exp_b[$], got_b[$];
  rbeat_t exp_r[$], got_r[$];
  logic [31:0] exp_tx[$], got_tx[$];
  int got_tx_cyc[$];

  ps_axi_fifo_bridge #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id), .s_aw_len(s_aw_len),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id), .s_ar_len(s_ar_len),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_id(s_r_id), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock)
    if (!reset && tx_valid && tx_ready) begin
      got_tx.push_back(tx_data);
      got_tx_cyc.push_back(cyc);
    end

  task automatic timeout_fail(input string what);
    total++; bad++;
    $display("FAIL timeout_%s: handshake not seen within 200 cycles", what);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [ID_W-1:0] id, input logic [7:0] len, input logic [31:0] d0);
    int n;
    @(negedge clock);
    s_aw_valid = 1; s_aw_addr = addr; s_aw_id = id; s_aw_len = len;
    n = 0; while (!s_aw_ready && n < 200) begin @(negedge clock); n++; end
    if (!s_aw_ready) begin timeout_fail("aw"); s_aw_valid = 0; return; end
    @(posedge clock); #1 s_aw_valid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clock);
      s_w_valid = 1; s_w_data = d0 + 32'(i); s_w_last = (i == int'(len));
      n = 0; while (!s_w_ready && n < 200) begin @(negedge clock); n++; end
      if (!s_w_ready) begin timeout_fail("w"); s_w_valid = 0; return; end
      w_last_cyc = cyc;
      @(posedge clock); #1 s_w_valid = 0; s_w_last = 0;
    end
    @(negedge clock); s_b_ready = 1;
    n = 0; while (!s_b_valid && n < 200) begin @(negedge clock); n++; end
    if (!s_b_valid) begin timeout_fail("b"); s_b_ready = 0; return; end
    got_b.push_back({s_b_id, s_b_resp});
    @(posedge clock); #1 s_b_ready = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [ID_W-1:0] id, input logic [7:0] len);
    int n;
    @(negedge clock);
    s_ar_valid = 1; s_ar_addr = addr; s_ar_id = id; s_ar_len = len;
    n = 0; while (!s_ar_ready && n < 200) begin @(negedge clock); n++; end
    if (!s_ar_ready) begin timeout_fail("ar"); s_ar_valid = 0; return; end
    @(posedge clock); #1 s_ar_valid = 0; s_r_ready = 1;
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clock);
      n = 0; while (!s_r_valid && n < 200) begin @(negedge clock); n++; end
      if (!s_r_valid) begin timeout_fail("r"); s_r_ready = 0; return; end
      got_r.push_back({s_r_id, s_r_data, s_r_resp, s_r_last});
    end
    @(posedge clock); #1 s_r_ready = 0;
  endtask

  task automatic rx_push(input logic [31:0] d);
    int n;
    @(negedge clock); rx_valid = 1; rx_data = d;
    n = 0; while (!rx_ready && n < 200) begin @(negedge clock); n++; end
    if (!rx_ready) begin timeout_fail("rx"); rx_valid = 0; return; end
    @(posedge clock); #1 rx_valid = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    total++;
    if ({s_aw_ready, s_ar_ready, rx_ready} !== 3'b111) begin bad++;
      $display("FAIL reset_ready: got %b want 111", {s_aw_ready, s_ar_ready, rx_ready}); end
    total++;
    if ({s_w_ready, s_b_valid, s_r_valid, tx_valid} !== 4'b0) begin bad++;
      $display("FAIL reset_valid: got %b want 0000", {s_w_ready, s_b_valid, s_r_valid, tx_valid}); end
    total++;
    if ({s_b_id, s_b_resp, s_r_data, s_r_id, s_r_resp, s_r_last, tx_data} !== '0) begin bad++;
      $display("FAIL reset_data: b_id=%h b_resp=%b r_data=%h r_id=%h r_resp=%b last=%b tx=%h want all 0",
               s_b_id, s_b_resp, s_r_data, s_r_id, s_r_resp, s_r_last, tx_data); end
    reset = 0;
    @(negedge clock);
  endtask

  task automatic test_single_write;
    exp_b.push_back({12'h1A5, 2'b00});
    do_write(32'h0, 12'h1A5, 8'd0, 32'hDEADBEEF);
    repeat (3) @(negedge clock);
    total++;
    if (got_b.size() != 1 || got_b[0] !== exp_b[0]) begin bad++;
      $display("FAIL single_b: got %p want %h", got_b, exp_b[0]); end
    total++;
    if (got_tx.size() != 1 || got_tx[0] !== 32'hDEADBEEF) begin bad++;
      $display("FAIL single_tx: got %p want deadbeef", got_tx); end
    total++;
    if (got_tx_cyc.size() != 1 || got_tx_cyc[0] != w_last_cyc + 1) begin bad++;
      $display("FAIL single_tx_latency: got %p want %0d", got_tx_cyc, w_last_cyc + 1); end
    exp_b.delete(); got_b.delete(); got_tx.delete(); got_tx_cyc.delete();
  endtask

  task automatic test_tx_full;
    tx_ready = 0;
    for (int i = 0; i < 17; i++) begin
      exp_b.push_back({12'(i), (i < DEPTH) ? 2'b00 : 2'b10});
      if (i < DEPTH) exp_tx.push_back(32'h100 + 32'(i));
      do_write(32'h0, 12'(i), 8'd0, 32'h100 + 32'(i));
    end
    exp_r.push_back({12'h0F0, 32'd0, 2'b00, 1'b1});
    do_read(32'h04, 12'h0F0, 8'd0);
    tx_ready = 1;
    repeat (DEPTH + 4) @(negedge clock);
    exp_r.push_back({12'h0F1, 32'd16, 2'b00, 1'b1});
    do_read(32'h04, 12'h0F1, 8'd0);
    total++;
    if (got_b.size() != exp_b.size()) begin bad++;
      $display("FAIL full_b_count: got %0d want %0d", got_b.size(), exp_b.size()); end
    while (exp_b.size() > 0 && got_b.size() > 0) begin
      bbeat_t e = exp_b.pop_front(), g = got_b.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL full_b: got %h want %h", g, e); end
    end
    while (exp_r.size() > 0 && got_r.size() > 0) begin
      rbeat_t e = exp_r.pop_front(), g = got_r.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL full_free_read: got %h want %h", g, e); end
    end
    total++;
    if (got_tx != exp_tx) begin bad++;
      $display("FAIL full_tx_drain: got %0d words want %0d", got_tx.size(), exp_tx.size()); end
    exp_b.delete(); got_b.delete(); exp_r.delete(); got_r.delete();
    exp_tx.delete(); got_tx.delete(); got_tx_cyc.delete();
  endtask

  task automatic test_rx_read;
    for (int i = 0; i < 3; i++) rx_push(32'hA0 + 32'(i));
    exp_r.push_back({12'h011, 32'd3, 2'b00, 1'b1});
    do_read(32'h0C, 12'h011, 8'd0);
    for (int i = 0; i < 3; i++) exp_r.push_back({12'h022, 32'hA0 + 32'(i), 2'b00, 1'b0});
    exp_r.push_back({12'h022, 32'd0, 2'b10, 1'b1});
    do_read(32'h08, 12'h022, 8'd3);
    exp_r.push_back({12'h033, 32'd0, 2'b00, 1'b1});
    do_read(32'h0C, 12'h033, 8'd0);
    total++;
    if (got_r.size() != exp_r.size()) begin bad++;
      $display("FAIL rx_r_count: got %0d want %0d", got_r.size(), exp_r.size()); end
    while (exp_r.size() > 0 && got_r.size() > 0) begin
      rbeat_t e = exp_r.pop_front(), g = got_r.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL rx_read: got %h want %h", g, e); end
    end
    exp_r.delete(); got_r.delete();
  endtask

  task automatic test_unmapped;
    exp_b.push_back({12'h044, 2'b10});
    do_write(32'h20, 12'h044, 8'd0, 32'h1234);
    exp_b.push_back({12'h045, 2'b10});
    do_write(32'h04, 12'h045, 8'd1, 32'h1);
    exp_r.push_back({12'h055, 32'd0, 2'b10, 1'b1});
    do_read(32'h24, 12'h055, 8'd0);
    exp_r.push_back({12'h056, 32'd0, 2'b10, 1'b1});
    do_read(32'h10, 12'h056, 8'd0);
    total++;
    if (got_b != exp_b) begin bad++; $display("FAIL unmapped_b: got %p want %p", got_b, exp_b); end
    total++;
    if (got_r != exp_r) begin bad++; $display("FAIL unmapped_r: got %p want %p", got_r, exp_r); end
    total++;
    if (got_tx.size() != 0) begin bad++; $display("FAIL unmapped_tx: got %0d words want 0", got_tx.size()); end
    exp_b.delete(); got_b.delete(); exp_r.delete(); got_r.delete(); got_tx.delete(); got_tx_cyc.delete();
  endtask

  task automatic test_back_to_back;
    s_w_strb = 4'h0;
    for (int i = 0; i < 4; i++) exp_tx.push_back(32'h200 + 32'(i));
    exp_b.push_back({12'h066, 2'b00});
    do_write(32'h0, 12'h066, 8'd3, 32'h200);
    repeat (3) @(negedge clock);
    total++;
    if (got_tx != exp_tx || got_tx_cyc.size() != 4 || got_tx_cyc[3] != got_tx_cyc[0] + 3) begin bad++;
      $display("FAIL b2b_tx: got %p want %p", got_tx, exp_tx); end
    exp_tx.delete(); got_tx.delete(); got_tx_cyc.delete();
    tx_ready = 0;
    for (int i = 0; i < DEPTH; i++) exp_tx.push_back(32'h300 + 32'(i));
    exp_b.push_back({12'h077, 2'b10});
    do_write(32'h0, 12'h077, 8'd17, 32'h300);
    tx_ready = 1;
    repeat (DEPTH + 4) @(negedge clock);
    total++;
    if (got_b != exp_b) begin bad++; $display("FAIL b2b_b: got %p want %p", got_b, exp_b); end
    total++;
    if (got_tx != exp_tx) begin bad++;
      $display("FAIL b2b_overflow_tx: got %0d words want %0d", got_tx.size(), exp_tx.size()); end
    s_w_strb = 4'hF;
    exp_b.delete(); got_b.delete(); exp_tx.delete(); got_tx.delete(); got_tx_cyc.delete();
  endtask

  task automatic test_concurrent;
    for (int i = 0; i < 8; i++) exp_tx.push_back(32'h400 + 32'(i));
    exp_b.push_back({12'h088, 2'b00});
    fork
      do_write(32'h0, 12'h088, 8'd7, 32'h400);
      do_read(32'h0C, 12'h099, 8'd7);
      for (int i = 0; i < 4; i++) rx_push(32'h500 + 32'(i));
    join
    repeat (3) @(negedge clock);
    total++;
    if (got_b != exp_b) begin bad++; $display("FAIL conc_b: got %p want %p", got_b, exp_b); end
    total++;
    if (got_tx != exp_tx) begin bad++; $display("FAIL conc_tx: got %p want %p", got_tx, exp_tx); end
    total++;
    if (got_r.size() != 8) begin bad++; $display("FAIL conc_r_count: got %0d want 8", got_r.size()); end
    for (int i = 0; i < got_r.size(); i++) begin
      total++;
      if (got_r[i][2:1] !== 2'b00 || got_r[i][0] !== (i == 7) || got_r[i][ID_W+34:35] !== 12'h099 ||
          got_r[i][34:3] > 32'd4 || (i > 0 && got_r[i][34:3] < got_r[i-1][34:3])) begin bad++;
        $display("FAIL conc_r_beat%0d: got %h (prev data %h) want OKAY non-decreasing count", i, got_r[i],
                 (i > 0) ? got_r[i-1][34:3] : 32'd0); end
    end
    got_r.delete();
    for (int i = 0; i < 4; i++) exp_r.push_back({12'h0AA, 32'h500 + 32'(i), 2'b00, (i == 3)});
    do_read(32'h08, 12'h0AA, 8'd3);
    total++;
    if (got_r != exp_r) begin bad++; $display("FAIL conc_rx_drain: got %p want %p", got_r, exp_r); end
    exp_b.delete(); got_b.delete(); exp_r.delete(); got_r.delete(); exp_tx.delete(); got_tx.delete(); got_tx_cyc.delete();
  endtask

  task automatic test_reset_mid_read;
    int n, beats;
    @(negedge clock); s_ar_valid = 1; s_ar_addr = 32'h0C; s_ar_id = 12'h0BB; s_ar_len = 8'd7;
    n = 0; while (!s_ar_ready && n < 200) begin @(negedge clock); n++; end
    if (!s_ar_ready) begin timeout_fail("ar_mid"); s_ar_valid = 0; return; end
    @(posedge clock); #1 s_ar_valid = 0;
    repeat (2) @(negedge clock);
    total++;
    if (s_r_valid !== 1'b1) begin bad++; $display("FAIL midrst_in_rdata: got r_valid=%b want 1", s_r_valid); end
    reset = 1;
    @(negedge clock);
    reset = 0; s_r_ready = 1;
    beats = 0;
    repeat (10) begin @(negedge clock); if (s_r_valid) beats++; end
    s_r_ready = 0;
    total++;
    if (beats != 0) begin bad++; $display("FAIL midrst_beats: got %0d beats want 0", beats); end
    total++;
    if (s_ar_ready !== 1'b1) begin bad++; $display("FAIL midrst_ar_ready: got %b want 1", s_ar_ready); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_tx_full();
    test_rx_read();
    test_unmapped();
    test_back_to_back();
    test_concurrent();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ps_axi_fifo_bridge.md
PS_AXI_FIFO_BRIDGE -- requirements
Module: ps_axi_fifo_bridge

Interface
REQ-001 Parameter DEPTH, default 16, entries per FIFO (power of two, 2..256).
REQ-002 Parameter ID_W, default 12, AXI ID width.
REQ-003 clock  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 s_aw_valid/ready, s_aw_addr[31:0], s_aw_id[ID_W], s_aw_len[7:0]: AXI4 write-address channel from PS master.
REQ-006 s_w_valid/ready, s_w_data[31:0], s_w_strb[3:0], s_w_last: write-data channel.
REQ-007 s_b_valid/ready, s_b_id[ID_W], s_b_resp[1:0]: write-response channel.
REQ-008 s_ar_valid/ready, s_ar_addr[31:0], s_ar_id[ID_W], s_ar_len[7:0]: read-address channel.
REQ-009 s_r_valid/ready, s_r_data[31:0], s_r_id[ID_W], s_r_resp[1:0], s_r_last: read-data channel.
REQ-010 tx_valid/ready, tx_data[31:0]  out  stream to target, from TX FIFO head.
REQ-011 rx_valid/ready, rx_data[31:0]  in  stream from target into RX FIFO.

Function
REQ-012 Register map on addr[7:0]: 0x00 TX data (W), 0x04 TX free count (R), 0x08 RX data (R, pop), 0x0C RX occupancy (R); other offsets unmapped.
REQ-013 Write FSM: W_IDLE -> (aw accepted) W_DATA -> (beat with s_w_last accepted) W_RESP -> (b handshake) W_IDLE; s_aw_ready=1 only in W_IDLE, s_w_ready=1 only in W_DATA.
REQ-014 Every beat of a burst targets the start-address register (fixed semantics); s_b_resp=OKAY unless any beat errored, then SLVERR (2'b10); s_b_id=captured s_aw_id.
REQ-015 Beat to 0x00 with TX not full pushes s_w_data (strobes ignored); TX full drops the beat and flags SLVERR; beats to other offsets are dropped with SLVERR.
REQ-016 Read FSM: R_IDLE -> (ar accepted, beat counter=s_ar_len) R_DATA -> after final beat handshake R_IDLE; s_ar_ready=1 only in R_IDLE.
REQ-017 In R_DATA s_r_valid=1, data computed combinationally from current state; s_r_last=1 when counter=0; s_r_id=captured s_ar_id.
REQ-018 Read 0x08 with RX non-empty returns head and pops on r handshake, OKAY; RX empty returns 0, SLVERR, no pop.
REQ-019 Reads of 0x04/0x0C return zero-extended count, OKAY; unmapped returns 0, SLVERR.
REQ-020 FIFOs first-word-fall-through: push visible at output the cycle after; tx_valid=!tx_empty; rx_ready=!rx_full.
REQ-021 Simultaneous push and pop on the same FIFO in one cycle are both honoured, including full (pop frees slot, push accepted only if not full at cycle start) and empty (no bypass).
REQ-022 Counts are $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-023 Write and read FSMs are independent and may be active concurrently.

Reset
REQ-024 On reset: both FSMs idle, FIFOs empty, all valid outputs 0, s_aw_ready=s_ar_ready=1, rx_ready=1, data/id/resp outputs 0.
REQ-025 Reset mid-burst abandons the transaction without issuing B or further R beats.

Configuration
REQ-026 With PS_BRIDGE_SOFT_RESET_EN defined: offset 0x10 R/W register, bit0 drives extra output soft_reset (1 bit, reset value 1); writing bit0=1 also empties both FIFOs next cycle.
REQ-027 Without PS_BRIDGE_SOFT_RESET_EN: no soft_reset port; 0x10 is unmapped.

Structure
REQ-028 Shared package holds register offsets, AXI resp codes (OKAY, SLVERR) and FSM state enums.
REQ-029 One sub-module, bridge_fifo (parameterised DEPTH, width 32, FWFT, count output), instantiated twice.

Verification
REQ-030 Write 0x00 len=0 data 0xDEADBEEF, tx_ready=1 -> B OKAY, tx_data=0xDEADBEEF one cycle later.
REQ-031 tx_ready=0, 17 single writes to 0x00 (DEPTH=16) -> 16 OKAY then SLVERR; read 0x04 -> 0.
REQ-032 Push 3 words on rx; read 0x08 len=3 -> three data beats OKAY, fourth 0 SLVERR with s_r_last=1; 0x0C -> 0.
REQ-033 Write to 0x20 and read 0x24 -> B SLVERR, R data 0 SLVERR.
REQ-034 Concurrent burst write to 0x00 and burst read of 0x0C -> both complete, read counts monotonic non-decreasing.
REQ-035 Assert reset during R_DATA -> no further R beats, s_ar_ready=1 after release.
